// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ARB_FIXED  = 2'd0,
    ARB_RR     = 2'd1,
    ARB_STATIC = 2'd2
  } arb_mode_e;

  localparam int LOCK_MAX_DEFAULT = 64;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotating priority pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  int  j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
    any = found;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for the shared RAM data port with lock, lock watchdog and
// read-return routing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MODE        = 0,
  parameter int READ_LAT    = 1,
  parameter int LOCK_MAX    = LOCK_MAX_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic [$clog2(NUM_MASTERS)-1:0]     i_owner,
  input  logic [NUM_MASTERS-1:0]             i_req,
  input  logic [NUM_MASTERS-1:0]             i_lock,
  input  logic [NUM_MASTERS-1:0]             i_read_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]      i_read_addr,
  input  logic [NUM_MASTERS-1:0]             i_write_enable,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0]  i_byte_enable,
  input  logic [NUM_MASTERS*ADDR_W-1:0]      i_write_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]      i_write_data,
  output logic [NUM_MASTERS-1:0]             o_grant,
  output logic [NUM_MASTERS-1:0]             o_read_valid,
  output logic [DATA_W-1:0]                  o_read_data,
  output logic                               o_lock_timeout,
  output logic                               o_read_req,
  output logic [ADDR_W-1:0]                  o_read_addr,
  output logic                               o_write_enable,
  output logic [DATA_W/8-1:0]                o_byte_enable,
  output logic [ADDR_W-1:0]                  o_write_addr,
  output logic [DATA_W-1:0]                  o_write_data,
  input  logic [DATA_W-1:0]                  i_read_data
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d, lock_id_q, lock_id_d, blk_id_q, blk_id_d;
  logic             lock_q, lock_d, blk_q, blk_d, lock_to_q, lock_to_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, cnt_next;
  logic [READ_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0] rd_id_q [READ_LAT];
  logic [IDX_W-1:0] rd_id_d [READ_LAT];

  logic [NUM_MASTERS-1:0] grant, pick_gnt;
  logic [IDX_W-1:0]       g_idx, pick_idx, pick_ptr;
  logic                   pick_any, any_grant, lock_ok;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (int'(v) == NUM_MASTERS - 1) ? '0 : v + IDX_W'(1);
  endfunction

  // Fixed priority is the rotating pick with the pointer pinned at 0.
  assign pick_ptr = (MODE == int'(ARB_RR)) ? ptr_q : '0;

  rr_pick #(.N(NUM_MASTERS), .PW(IDX_W)) u_pick (
    .req (i_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    grant = '0;
    g_idx = '0;
    if (lock_q && i_req[lock_id_q]) begin
      grant[lock_id_q] = 1'b1;
      g_idx            = lock_id_q;
    end else if (MODE == int'(ARB_STATIC)) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (i_req[i] && i_owner == IDX_W'(i)) begin
          grant[i] = 1'b1;
          g_idx    = IDX_W'(i);
        end
      end
    end else if (pick_any) begin
      grant = pick_gnt;
      g_idx = pick_idx;
    end
  end

  assign any_grant = |grant;

  always_comb begin
    o_read_req     = 1'b0;
    o_read_addr    = '0;
    o_write_enable = 1'b0;
    o_byte_enable  = '0;
    o_write_addr   = '0;
    o_write_data   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        o_read_req     = i_read_req[i];
        o_read_addr    = i_read_addr[i*ADDR_W +: ADDR_W];
        o_write_enable = i_write_enable[i];
        o_byte_enable  = i_byte_enable[i*BE_W +: BE_W];
        o_write_addr   = i_write_addr[i*ADDR_W +: ADDR_W];
        o_write_data   = i_write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A master whose lock timed out may not re-lock until it has lost the grant once.
  assign lock_ok = any_grant && i_lock[g_idx] && !(blk_q && g_idx == blk_id_q);

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    lock_cnt_d = lock_cnt_q;
    blk_d      = blk_q;
    blk_id_d   = blk_id_q;
    lock_to_d  = lock_to_q;
    rd_vld_d   = rd_vld_q;
    rd_id_d    = rd_id_q;
    cnt_next   = '0;
    if (clk_en) begin
      lock_to_d   = 1'b0;
      rd_vld_d[0] = o_read_req;
      rd_id_d[0]  = g_idx;
      for (int k = 1; k < READ_LAT; k++) begin
        rd_vld_d[k] = rd_vld_q[k-1];
        rd_id_d[k]  = rd_id_q[k-1];
      end
      if (any_grant && !lock_q) ptr_d = wrap_inc(g_idx);
      if (blk_q && !(any_grant && g_idx == blk_id_q)) blk_d = 1'b0;
      lock_d     = 1'b0;
      lock_cnt_d = '0;
      if (lock_ok) begin
        cnt_next = (lock_q && lock_id_q == g_idx) ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
        if (LOCK_MAX != 0 && cnt_next >= CNT_W'(LOCK_MAX)) begin
          lock_to_d = 1'b1;
          blk_d     = 1'b1;
          blk_id_d  = g_idx;
          ptr_d     = wrap_inc(g_idx);
        end else begin
          lock_d     = 1'b1;
          lock_id_d  = g_idx;
          lock_cnt_d = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
      lock_cnt_q <= '0;
      blk_q      <= 1'b0;
      blk_id_q   <= '0;
      lock_to_q  <= 1'b0;
      rd_vld_q   <= '0;
      for (int k = 0; k < READ_LAT; k++) rd_id_q[k] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      lock_cnt_q <= lock_cnt_d;
      blk_q      <= blk_d;
      blk_id_q   <= blk_id_d;
      lock_to_q  <= lock_to_d;
      rd_vld_q   <= rd_vld_d;
      rd_id_q    <= rd_id_d;
    end
  end

  always_comb begin
    o_read_valid = '0;
    if (rd_vld_q[READ_LAT-1]) o_read_valid[rd_id_q[READ_LAT-1]] = 1'b1;
  end

  assign o_grant        = grant;
  assign o_read_data    = i_read_data;
  assign o_lock_timeout = lock_to_q;
endmodule
